mult_div_unit: RTL

// Multi-cycle MULT/MULTU/DIV/DIVU execution unit with architectural HI/LO registers.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/md_step.sv | 36 +++
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MULT/DIV unit, its decoder and the hazard unit.
package mips_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = MD_WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of radix-2 shift-add multiply or restoring divide on {upper, lower}.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shrem_s;
  logic [WIDTH:0] diff_s;

  // Next accumulator: multiply shifts right through the carry, divide shifts left in a quotient bit
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shrem_s  = acc[2*WIDTH-1:WIDTH-1];
    diff_s   = shrem_s - {1'b0, opnd};
    acc_next = {(2*WIDTH){1'b0}};
    if (is_div) begin
      if (!diff_s[WIDTH]) begin
        acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shrem_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum_s, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER = WIDTH;
  localparam int CW   = $clog2(ITER);

  md_state_t          state_r, state_s;
  md_op_t             op_r;
  logic [CW-1:0]      cnt_r;
  logic               ld_r;
  logic [WIDTH-1:0]   a_r, b_r, opnd_r;
  logic [2*WIDTH-1:0] acc_r, step_s, prod_s;
  logic               neg_q_r, neg_r_r, dz_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r, hi_s, lo_s;
  logic               div_s, sgn_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_s),
    .acc      (acc_r),
    .opnd     (opnd_r),
    .acc_next (step_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: first CALC cycle loads magnitudes, then ITER steps; flush always returns to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      MD_IDLE: begin
        if (start && !flush) state_s = MD_CALC;
        else                 state_s = MD_IDLE;
      end
      MD_CALC: begin
        if (flush)                             state_s = MD_IDLE;
        else if (!ld_r && cnt_r == {CW{1'b0}}) state_s = MD_FIX;
        else                                   state_s = MD_CALC;
      end
      MD_FIX:  state_s = MD_IDLE;
      default: state_s = MD_IDLE;
    endcase
  end

  // Operands are captured raw so the negators stay off the forwarded rs/rt path
  always_comb begin
    div_s   = md_is_div(op_r);
    sgn_s   = md_is_signed(op_r);
    mag_a_s = (sgn_s && a_r[WIDTH-1]) ? -a_r : a_r;
    mag_b_s = (sgn_s && b_r[WIDTH-1]) ? -b_r : b_r;
  end

  // Operand capture, magnitude load and iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r    <= MD_MULT;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
      ld_r    <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start && !flush) begin
            op_r  <= md_op_t'(op);
            a_r   <= a;
            b_r   <= b;
            ld_r  <= 1'b1;
            cnt_r <= CW'(ITER - 1);
          end
        end
        MD_CALC: begin
          if (ld_r) begin
            ld_r    <= 1'b0;
            acc_r   <= {{WIDTH{1'b0}}, (div_s ? mag_a_s : mag_b_s)};
            opnd_r  <= div_s ? mag_b_s : mag_a_s;
            neg_q_r <= sgn_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_r_r <= sgn_s & div_s & a_r[WIDTH-1];
            dz_r    <= div_s & (b_r == {WIDTH{1'b0}});
          end else begin
            acc_r <= step_s;
            cnt_r <= cnt_r - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sign fixup; a zero divisor leaves |a| as remainder, so re-signing it restores a
  always_comb begin
    prod_s = neg_q_r ? -acc_r : acc_r;
    quo_s  = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (div_s) begin
      hi_s = rem_s;
      lo_s = dz_r ? {WIDTH{1'b1}} : quo_s;
    end else begin
      hi_s = prod_s[2*WIDTH-1:WIDTH];
      lo_s = prod_s[WIDTH-1:0];
    end
  end

  // HI/LO, busy and done; a flush in FIX suppresses the result write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != MD_IDLE);
      done_r <= 1'b0;
      if (state_r == MD_FIX && !flush) begin
        hi_r   <= hi_s;
        lo_r   <= lo_s;
        done_r <= 1'b1;
      end else if (state_r == MD_IDLE) begin
        if (hi_we) hi_r <= wdata;
        if (lo_we) lo_r <= wdata;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
